// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - IF lookup / EX resolve signal bundle for branch_predict_unit
//
// Purpose : groups the fetch-side prediction port and the execute-side
//           resolve port of the branch predictor.
// Modports: master - pipeline side (drives PCs/operands, receives prediction/redirect)
//           slave  - predictor side (branch_predict_unit)
// Signals : if_pc_i, if_pred_taken_o, if_pred_target_o                 (fetch lookup)
//           ex_valid_i, ex_pc_i, ex_is_branch_i/jal_i/jalr_i, ex_funct3_i,
//           ex_rs1_i, ex_rs2_i, ex_pc_imm_target_i, ex_alu_target_i,
//           ex_pred_taken_i, ex_pred_target_i                          (execute resolve)
//           pc_src_optn_o, flush_req_o, final_target_addr_o            (redirect)
interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] if_pc_i;
   logic            if_pred_taken_o;
   logic [XLEN-1:0] if_pred_target_o;
   logic            ex_valid_i;
   logic [XLEN-1:0] ex_pc_i;
   logic            ex_is_branch_i;
   logic            ex_is_jal_i;
   logic            ex_is_jalr_i;
   logic [2:0]      ex_funct3_i;
   logic [XLEN-1:0] ex_rs1_i;
   logic [XLEN-1:0] ex_rs2_i;
   logic [XLEN-1:0] ex_pc_imm_target_i;
   logic [XLEN-1:0] ex_alu_target_i;
   logic            ex_pred_taken_i;
   logic [XLEN-1:0] ex_pred_target_i;
   logic            pc_src_optn_o;
   logic            flush_req_o;
   logic [XLEN-1:0] final_target_addr_o;

   modport master (
      output if_pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i,
             ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_pc_imm_target_i, ex_alu_target_i,
             ex_pred_taken_i, ex_pred_target_i,
      input  if_pred_taken_o, if_pred_target_o, pc_src_optn_o, flush_req_o,
             final_target_addr_o
   );

   modport slave (
      input  if_pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i,
             ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_pc_imm_target_i, ex_alu_target_i,
             ex_pred_taken_i, ex_pred_target_i,
      output if_pred_taken_o, if_pred_target_o, pc_src_optn_o, flush_req_o,
             final_target_addr_o
   );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped 2-bit BHT + tagged BTB with EX-stage resolve
//
// Purpose : serves a combinational taken/target prediction to IF, resolves
//           RV32 conditional branches, JAL and JALR in EX, raises redirect/flush
//           on a misprediction and trains the table at the end of the EX cycle.
// Ports   : clk_i   - clock, rising edge
//           rst_ni  - asynchronous active-low reset
//           bus     - branch_predict_unit_if.slave (fetch lookup + execute resolve)
//           perf_branches_o, perf_mispredicts_o - 32-bit event counters,
//           present only when BPU_PERF_CNT_EN is defined
// Macro   : BPU_PERF_CNT_EN - adds the performance counters
module branch_predict_unit #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   branch_predict_unit_if.slave  bus
`ifdef BPU_PERF_CNT_EN
   ,
   output logic [31:0]           perf_branches_o,
   output logic [31:0]           perf_mispredicts_o
`endif
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;

   assign if_idx = bus.if_pc_i[IDX_W+1:2];
   assign if_tag = bus.if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign ex_idx = bus.ex_pc_i[IDX_W+1:2];
   assign ex_tag = bus.ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

   // Only the index/tag bits of the fetch PC matter.
   logic unused_if_pc;
   assign unused_if_pc = ^bus.if_pc_i;

   // Fetch lookup reads the registered table only, so a same-cycle EX update
   // to the same entry is not visible until the next cycle.
   assign if_hit               = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign bus.if_pred_taken_o  = if_hit && ctr_q[if_idx][1];
   assign bus.if_pred_target_o = bus.if_pred_taken_o ? target_q[if_idx] : '0;

   // Branch condition.
   logic cond_eq, cond_lt, cond_ltu, cond;
   assign cond_eq  = (bus.ex_rs1_i == bus.ex_rs2_i);
   assign cond_lt  = ($signed(bus.ex_rs1_i) < $signed(bus.ex_rs2_i));
   assign cond_ltu = (bus.ex_rs1_i < bus.ex_rs2_i);

   always_comb begin
      cond = 1'b0;
      case (bus.ex_funct3_i)
         3'b000:  cond = cond_eq;
         3'b001:  cond = !cond_eq;
         3'b100:  cond = cond_lt;
         3'b101:  cond = !cond_lt;
         3'b110:  cond = cond_ltu;
         3'b111:  cond = !cond_ltu;
         default: cond = 1'b0;
      endcase
   end

   logic            act_taken, mispredict;
   logic [XLEN-1:0] act_target;

   assign act_taken  = bus.ex_valid_i &
                       (bus.ex_is_jal_i | bus.ex_is_jalr_i | (bus.ex_is_branch_i & cond));
   assign act_target = bus.ex_is_jalr_i ? (bus.ex_alu_target_i & ~XLEN'(1))
                                        : bus.ex_pc_imm_target_i;
   // A non-control instruction predicted taken through aliasing also lands here.
   assign mispredict = bus.ex_valid_i &
                       ((act_taken != bus.ex_pred_taken_i) |
                        (act_taken & (bus.ex_pred_target_i != act_target)));

   assign bus.pc_src_optn_o       = mispredict;
   assign bus.flush_req_o         = mispredict;
   assign bus.final_target_addr_o = !bus.ex_valid_i ? '0 :
                                    act_taken       ? act_target :
                                                      bus.ex_pc_i + XLEN'(4);

   // Training. Hit is recomputed from the table at the EX PC because the
   // pipelined prediction may be stale after intervening updates.
   logic             is_bj;
   logic             upd_en;
   logic             upd_valid;
   logic [TAG_W-1:0] upd_tag;
   logic [XLEN-1:0]  upd_target;
   logic [1:0]       upd_ctr;

   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign is_bj  = (bus.ex_is_branch_i | bus.ex_is_jal_i) & ~bus.ex_is_jalr_i;

   always_comb begin
      upd_en     = 1'b0;
      upd_valid  = valid_q[ex_idx];
      upd_tag    = tag_q[ex_idx];
      upd_target = target_q[ex_idx];
      upd_ctr    = ctr_q[ex_idx];
      if (bus.ex_valid_i) begin
         if (is_bj) begin
            if (ex_hit) begin
               upd_en = 1'b1;
               if (act_taken) begin
                  upd_target = act_target;
                  if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'd1;
               end else if (upd_ctr != 2'b00) begin
                  upd_ctr = upd_ctr - 2'd1;
               end
            end else if (act_taken) begin
               upd_en     = 1'b1;
               upd_valid  = 1'b1;
               upd_tag    = ex_tag;
               upd_target = act_target;
               upd_ctr    = bus.ex_is_jal_i ? 2'b11 : 2'b10;
            end
         end else if (ex_hit) begin
            // JALR targets vary per call and non-control hits are aliases: drop them.
            upd_en    = 1'b1;
            upd_valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (upd_en) begin
         valid_q[ex_idx]  <= upd_valid;
         tag_q[ex_idx]    <= upd_tag;
         target_q[ex_idx] <= upd_target;
         ctr_q[ex_idx]    <= upd_ctr;
      end
   end

`ifdef BPU_PERF_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_branches_o    <= '0;
         perf_mispredicts_o <= '0;
      end else begin
         if (bus.ex_valid_i & (bus.ex_is_branch_i | bus.ex_is_jal_i | bus.ex_is_jalr_i))
            perf_branches_o <= perf_branches_o + 32'd1;
         if (mispredict)
            perf_mispredicts_o <= perf_mispredicts_o + 32'd1;
      end
   end
`else
   // Counters are absent in this build.
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;
   localparam int TAG_W   = 8;

   logic clk    = 1'b0;
   logic rst_ni = 1'b1;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.XLEN(XLEN)) bus ();
`ifdef BPU_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
`ifdef BPU_PERF_CNT_EN
      ,
      .perf_branches_o    (perf_branches),
      .perf_mispredicts_o (perf_mispredicts)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per-entry records with an integer confidence 0..3.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int unsigned m_br_cnt, m_misp_cnt;

   function automatic int unsigned idx_of(logic [31:0] pc);
      int unsigned p = pc;
      return (p / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(logic [31:0] pc);
      int unsigned p = pc;
      return (p / (4 * ENTRIES)) % (1 << TAG_W);
   endfunction

   function automatic bit m_pred_taken(logic [31:0] pc);
      int unsigned i = idx_of(pc);
      return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(logic [31:0] pc);
      return m_pred_taken(pc) ? m_target[idx_of(pc)] : 32'h0;
   endfunction

   function automatic bit m_cond(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_act_taken();
      return bus.ex_valid_i && (bus.ex_is_jal_i || bus.ex_is_jalr_i ||
             (bus.ex_is_branch_i && m_cond(bus.ex_funct3_i, bus.ex_rs1_i, bus.ex_rs2_i)));
   endfunction

   function automatic logic [31:0] m_act_target();
      return bus.ex_is_jalr_i ? (bus.ex_alu_target_i & 32'hFFFF_FFFE) : bus.ex_pc_imm_target_i;
   endfunction

   function automatic bit m_misp();
      bit tk = m_act_taken();
      return bus.ex_valid_i &&
             ((tk != bus.ex_pred_taken_i) || (tk && (bus.ex_pred_target_i != m_act_target())));
   endfunction

   function automatic logic [31:0] m_addr();
      if (!bus.ex_valid_i) return 32'h0;
      return m_act_taken() ? m_act_target() : bus.ex_pc_i + 32'd4;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
      end
      m_br_cnt = 0; m_misp_cnt = 0;
   endfunction

   function automatic void model_train();
      int unsigned i, t;
      bit          hit, tk;
      logic [31:0] tg;
      if (!bus.ex_valid_i) return;
      i   = idx_of(bus.ex_pc_i);
      t   = tag_of(bus.ex_pc_i);
      hit = m_valid[i] && (m_tag[i] == t);
      tk  = m_act_taken();
      tg  = m_act_target();
      if (bus.ex_is_branch_i || bus.ex_is_jal_i || bus.ex_is_jalr_i) m_br_cnt++;
      if (m_misp()) m_misp_cnt++;
      if (bus.ex_is_jalr_i || !(bus.ex_is_branch_i || bus.ex_is_jal_i)) begin
         if (hit) m_valid[i] = 0;
      end else if (hit) begin
         if (tk) begin
            m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = tg;
         end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (tk) begin
         m_valid[i] = 1; m_tag[i] = t; m_target[i] = tg;
         m_ctr[i]   = bus.ex_is_jal_i ? 3 : 2;
      end
   endfunction

   task automatic drive_ex(input bit v, input logic [31:0] pc, input bit br, input bit jal,
                           input bit jalr, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pcimm,
                           input logic [31:0] alu, input bit pt, input logic [31:0] ptgt);
      bus.ex_valid_i = v;    bus.ex_pc_i = pc;
      bus.ex_is_branch_i = br; bus.ex_is_jal_i = jal; bus.ex_is_jalr_i = jalr;
      bus.ex_funct3_i = f3;  bus.ex_rs1_i = rs1; bus.ex_rs2_i = rs2;
      bus.ex_pc_imm_target_i = pcimm; bus.ex_alu_target_i = alu;
      bus.ex_pred_taken_i = pt; bus.ex_pred_target_i = ptgt;
   endtask

   task automatic idle_ex();
      drive_ex(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
   endtask

   // One EX cycle: table write at the rising edge, model follows, return at negedge.
   task automatic tick();
      @(posedge clk);
      model_train();
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.if_pc_i = 32'h100;
      drive_ex(0, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h140, 0, 0, 0);
      #1 rst_ni = 1'b0;
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", bus.if_pred_taken_o); end
      checks++; if (bus.if_pred_target_o !== 32'h0) begin errors++; $display("FAIL reset_pred_target got %h exp 0", bus.if_pred_target_o); end
      checks++; if (bus.pc_src_optn_o !== 1'b0 || bus.flush_req_o !== 1'b0) begin errors++; $display("FAIL bubble_redirect got %0b/%0b exp 0/0", bus.pc_src_optn_o, bus.flush_req_o); end
      checks++; if (bus.final_target_addr_o !== 32'h0) begin errors++; $display("FAIL bubble_addr got %h exp 0", bus.final_target_addr_o); end
`ifdef BPU_PERF_CNT_EN
      checks++; if (perf_branches !== 0 || perf_mispredicts !== 0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_branches, perf_mispredicts); end
`endif
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_cold_beq();
      bus.if_pc_i = 32'h100;
      drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h140, 0, 0, 0);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b1 || bus.flush_req_o !== 1'b1) begin errors++; $display("FAIL cold_redirect got %0b/%0b exp 1/1", bus.pc_src_optn_o, bus.flush_req_o); end
      checks++; if (bus.final_target_addr_o !== 32'h140) begin errors++; $display("FAIL cold_addr got %h exp 140", bus.final_target_addr_o); end
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL cold_pred_before got %0b exp 0", bus.if_pred_taken_o); end
      tick();
      idle_ex();
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1 || bus.if_pred_target_o !== 32'h140) begin errors++; $display("FAIL cold_pred_after got %0b %h exp 1 140", bus.if_pred_taken_o, bus.if_pred_target_o); end
   endtask

   task automatic test_saturation();
      bus.if_pc_i = 32'h100;
      drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 6, 32'h140, 0, 1, 32'h140);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b1 || bus.final_target_addr_o !== 32'h104) begin errors++; $display("FAIL sat_nt1 got %0b %h exp 1 104", bus.pc_src_optn_o, bus.final_target_addr_o); end
      tick();
      for (int k = 0; k < 2; k++) begin
         drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 6, 32'h140, 0, 0, 0);
         #1;
         checks++; if (bus.pc_src_optn_o !== 1'b0 || bus.final_target_addr_o !== 32'h104) begin errors++; $display("FAIL sat_nt%0d got %0b %h exp 0 104", k + 2, bus.pc_src_optn_o, bus.final_target_addr_o); end
         tick();
      end
      // From 00, two taken resolves must step 01 then 10 (no wrap to 11).
      for (int k = 0; k < 2; k++) begin
         drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h140, 0, 0, 0);
         #1;
         checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_floor%0d got %0b exp 0", k, bus.if_pred_taken_o); end
         checks++; if (bus.pc_src_optn_o !== 1'b1) begin errors++; $display("FAIL sat_tk_redirect%0d got %0b exp 1", k, bus.pc_src_optn_o); end
         tick();
      end
      idle_ex();
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1 || bus.if_pred_target_o !== 32'h140) begin errors++; $display("FAIL sat_recover got %0b %h exp 1 140", bus.if_pred_taken_o, bus.if_pred_target_o); end
   endtask

   task automatic test_signed_unsigned();
      logic [2:0] f3s  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd2, 3'd3};
      bit         exps [6] = '{1, 0, 0, 1, 0, 0};
      logic [31:0] pc;
      for (int k = 0; k < 6; k++) begin
         pc = 32'h300 + 32'h10 * k;
         drive_ex(1, pc, 1, 0, 0, f3s[k], 32'hFFFF_FFFF, 32'h1, 32'h400, 0, 0, 0);
         #1;
         checks++; if (bus.pc_src_optn_o !== exps[k] || bus.final_target_addr_o !== (exps[k] ? 32'h400 : pc + 4)) begin errors++; $display("FAIL cond_f3_%0d got %0b %h exp %0b", f3s[k], bus.pc_src_optn_o, bus.final_target_addr_o, exps[k]); end
         tick();
      end
   endtask

   task automatic test_jalr();
      drive_ex(1, 32'h10500, 0, 1, 0, 3'd0, 0, 0, 32'h3000, 0, 0, 0);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b1 || bus.final_target_addr_o !== 32'h3000) begin errors++; $display("FAIL jal_redirect got %0b %h exp 1 3000", bus.pc_src_optn_o, bus.final_target_addr_o); end
      tick();
      idle_ex();
      bus.if_pc_i = 32'h500;
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1 || bus.if_pred_target_o !== 32'h3000) begin errors++; $display("FAIL alias_hit got %0b %h exp 1 3000", bus.if_pred_taken_o, bus.if_pred_target_o); end
      drive_ex(1, 32'h500, 0, 0, 1, 3'd0, 0, 0, 0, 32'h2001, 1, 32'h3000);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b1 || bus.final_target_addr_o !== 32'h2000) begin errors++; $display("FAIL jalr_redirect got %0b %h exp 1 2000", bus.pc_src_optn_o, bus.final_target_addr_o); end
      tick();
      idle_ex();
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL jalr_invalidate got %0b exp 0", bus.if_pred_taken_o); end
      drive_ex(1, 32'h900, 0, 0, 1, 3'd0, 0, 0, 0, 32'h2001, 1, 32'h2000);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b0 || bus.final_target_addr_o !== 32'h2000) begin errors++; $display("FAIL jalr_correct got %0b %h exp 0 2000", bus.pc_src_optn_o, bus.final_target_addr_o); end
      tick();
   endtask

   task automatic test_collision();
      bus.if_pc_i = 32'h600;
      drive_ex(1, 32'h600, 1, 0, 0, 3'd1, 1, 2, 32'h680, 0, 0, 0);
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL collide_old got %0b exp 0", bus.if_pred_taken_o); end
      tick();
      drive_ex(1, 32'h600, 1, 0, 0, 3'd1, 1, 1, 32'h680, 0, 1, 32'h680);
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1 || bus.if_pred_target_o !== 32'h680) begin errors++; $display("FAIL collide_new got %0b %h exp 1 680", bus.if_pred_taken_o, bus.if_pred_target_o); end
      tick();
      drive_ex(1, 32'h600, 1, 0, 0, 3'd1, 1, 2, 32'h680, 0, 0, 0);
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL b2b_first got %0b exp 0", bus.if_pred_taken_o); end
      tick();
      idle_ex();
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL b2b_second got %0b exp 1", bus.if_pred_taken_o); end
   endtask

   task automatic test_random();
      logic [31:0] pc, ifpc, ptgt;
      int          cls;
      bit          pt;
      for (int n = 0; n < 300; n++) begin
         pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         ifpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         cls  = $urandom_range(0, 3);
         if ($urandom_range(0, 1)) begin
            pt = m_pred_taken(pc); ptgt = m_pred_target(pc);
         end else begin
            pt = 1'($urandom_range(0, 1)); ptgt = {$urandom_range(0, 15), 2'b00};
         end
         bus.if_pc_i = ifpc;
         drive_ex($urandom_range(0, 7) != 0, pc, cls == 0, cls == 1, cls == 2,
                  3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                  {$urandom_range(0, 15), 2'b00}, $urandom_range(0, 63), pt, ptgt);
         if ($urandom_range(0, 3) == 0) begin
            bus.ex_rs1_i = $urandom(); bus.ex_rs2_i = $urandom();
         end
         #1;
         checks++; if (bus.if_pred_taken_o !== m_pred_taken(ifpc)) begin errors++; $display("FAIL rnd_pred_taken n=%0d got %0b exp %0b", n, bus.if_pred_taken_o, m_pred_taken(ifpc)); end
         checks++; if (bus.if_pred_target_o !== m_pred_target(ifpc)) begin errors++; $display("FAIL rnd_pred_target n=%0d got %h exp %h", n, bus.if_pred_target_o, m_pred_target(ifpc)); end
         checks++; if (bus.pc_src_optn_o !== m_misp() || bus.flush_req_o !== m_misp()) begin errors++; $display("FAIL rnd_redirect n=%0d got %0b/%0b exp %0b", n, bus.pc_src_optn_o, bus.flush_req_o, m_misp()); end
         checks++; if (bus.final_target_addr_o !== m_addr()) begin errors++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, bus.final_target_addr_o, m_addr()); end
         tick();
      end
      idle_ex();
`ifdef BPU_PERF_CNT_EN
      #1;
      checks++; if (perf_branches !== m_br_cnt || perf_mispredicts !== m_misp_cnt) begin errors++; $display("FAIL rnd_perf got %0d/%0d exp %0d/%0d", perf_branches, perf_mispredicts, m_br_cnt, m_misp_cnt); end
`endif
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2; k++) begin
         drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h140, 0, 0, 0);
         tick();
      end
      bus.if_pc_i = 32'h100;
      drive_ex(1, 32'h700, 1, 0, 0, 3'd0, 7, 7, 32'h780, 0, 0, 0);
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got %0b exp 1", bus.if_pred_taken_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0 || bus.if_pred_target_o !== 32'h0) begin errors++; $display("FAIL async_pred got %0b %h exp 0 0", bus.if_pred_taken_o, bus.if_pred_target_o); end
`ifdef BPU_PERF_CNT_EN
      checks++; if (perf_branches !== 0 || perf_mispredicts !== 0) begin errors++; $display("FAIL async_perf got %0d/%0d exp 0/0", perf_branches, perf_mispredicts); end
`endif
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      model_reset();
      idle_ex();
      bus.if_pc_i = 32'h700;
      #1;
      checks++; if (bus.if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL dropped_update got %0b exp 0", bus.if_pred_taken_o); end
      drive_ex(1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h140, 0, 0, 0);
      #1;
      checks++; if (bus.pc_src_optn_o !== 1'b1 || bus.final_target_addr_o !== 32'h140) begin errors++; $display("FAIL post_reset_misp got %0b %h exp 1 140", bus.pc_src_optn_o, bus.final_target_addr_o); end
      tick();
      idle_ex();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      idle_ex();
      bus.if_pc_i = 32'h0;
      model_reset();
      test_reset();
      test_cold_beq();
      test_saturation();
      test_signed_unsigned();
      test_jalr();
      test_collision();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic successor to the static not-taken execute-stage flow control. It holds a direct-mapped branch history table (BHT) of 2-bit saturating counters with a tagged branch target buffer (BTB). It serves a combinational prediction to IF and resolves all six RV32 conditional branches plus JAL/JALR in EX. On a misprediction it raises redirect/flush with the corrected fetch address and trains the table on the following clock edge.

## Interface
- `XLEN`, 32, datapath/address width
- `ENTRIES`, 64, BHT/BTB depth; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`
- `TAG_W`, 8, tag bits stored per entry; `IDX_W+TAG_W+2 ≤ XLEN`

- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `if_pc_i` in XLEN: fetch PC
- `if_pred_taken_o` out 1: predict taken
- `if_pred_target_o` out XLEN: predicted target (valid when taken)
- `ex_valid_i` in 1: EX holds a real instruction (not a bubble)
- `ex_pc_i` in XLEN: EX instruction PC
- `ex_is_branch_i`, `ex_is_jal_i`, `ex_is_jalr_i` in 1 each: decoded control class
- `ex_funct3_i` in 3: branch condition
- `ex_rs1_i`, `ex_rs2_i` in XLEN: forwarded operands
- `ex_pc_imm_target_i` in XLEN: PC+imm (branch/JAL)
- `ex_alu_target_i` in XLEN: rs1+imm (JALR)
- `ex_pred_taken_i` in 1, `ex_pred_target_i` in XLEN: prediction carried down the pipeline from IF
- `pc_src_optn_o` out 1: 1 = redirect fetch
- `flush_req_o` out 1: flush IF/ID and ID/EX
- `final_target_addr_o` out XLEN: corrected fetch address

## Operation
- **Index and tag.** `idx = pc[IDX_W+1:2]`; `tag = pc[IDX_W+TAG_W+1:IDX_W+2]`. Each entry holds `valid`, `tag`, `target[XLEN-1:0]`, and `ctr[1:0]`.
- **Prediction.** `if_pred_taken_o = valid & tag match & ctr[1]`. `if_pred_target_o = target[idx]`, or 0 when not taken.
- **Condition evaluation.**
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: signed <
  - 101 BGE: signed ≥
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned ≥
  - 010/011: never taken
- **Actual outcome.**
  - `act_taken = jal | jalr | (branch & cond)`
  - `act_target = jalr ? (alu_target & ~1) : pc_imm_target`
- **Mispredict.** `ex_valid_i & ((act_taken != ex_pred_taken_i) | (act_taken & ex_pred_target_i != act_target))`. This covers a non-control instruction that was predicted taken through aliasing.
- **Outputs.** `pc_src_optn_o = flush_req_o = mispredict`. `final_target_addr_o = act_taken ? act_target : ex_pc_i + 4`, computed modulo 2^XLEN.
- **Training** (only when `ex_valid_i`). Hit is re-evaluated from the table at `ex_pc_i`, not taken from the pipelined prediction.
  - Branch or JAL, hit: `ctr` saturates up if taken, down if not taken (00↔11, no wrap). `target` is written when taken.
  - Branch or JAL, miss and taken: allocate with `valid=1`, tag, target. `ctr=10` for a branch, `11` for JAL.
  - Branch, miss and not taken: no write.
  - JALR or non-control instruction, hit: clear `valid`. There is no other write.
- **Reset.** All `valid=0`, all `ctr=01`, targets and tags 0. `if_pred_taken_o=0` and `if_pred_target_o=0` immediately on assertion.

## Timing
- Prediction and resolve outputs are purely combinational in the same cycle. EX outputs are 0 whenever `ex_valid_i=0`.
- The table write happens at the rising edge ending the EX cycle, so there is a 1-cycle training latency.
- Simultaneous IF lookup and EX update at the same index: IF sees the pre-update contents. There is no bypass.
- Back-to-back EX updates to the same index apply in order, one per cycle.
- Reset asserted mid-operation: state clears asynchronously and any in-flight update is dropped. Deassertion is synchronised externally.

## Configuration
- `BPU_PERF_CNT_EN` defined: adds outputs `perf_branches_o` and `perf_mispredicts_o`, each 32 bits.
  - `perf_branches_o` increments on each valid EX branch, JAL or JALR; `perf_mispredicts_o` increments on each mispredict.
  - Both wrap modulo 2^32 and reset to 0.
- `BPU_PERF_CNT_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- **Cold BEQ.** After reset, EX BEQ at `0x100` with rs1=rs2=5, pred 0, target `0x140` -> redirect=1, addr `0x140`. Next cycle, IF at `0x100` gives taken=1, target `0x140`, ctr=10.
- **Saturation.** Same branch resolved not-taken twice from ctr=10 -> ctr 01 then 00. The first resolve has pred=1, so it redirects to `0x104`. The second has pred=0, so there is no redirect. A third not-taken resolve keeps ctr at 00.
- **Signed vs unsigned.** rs1=`0xFFFFFFFF`, rs2=1 -> BLT taken, BLTU not taken, BGE not taken, BGEU taken.
- **JALR.** JALR with `alu_target=0x2001`, pred 0 -> redirect to `0x2000`. Aliased hit at that index is invalidated.
- **Collision.** Lookup and update of the same idx in one cycle -> IF returns old entry; new entry is visible the next cycle.
- **Async reset.** Assert `rst_ni` mid-run with counters nonzero (macro on) -> `if_pred_taken_o=0` and perf counters 0 immediately. A prior taken branch then mispredicts again.
